// File: rtl/apb_pkg.sv
// Shared constants and FSM encoding for the APB register-file completer.
package apb_pkg;

    localparam int unsigned DATA_WIDTH       = 8;
    localparam int unsigned ADDR_WIDTH       = 8;
    localparam int unsigned UPPER_ADDR_LIMIT = 200;
    localparam int unsigned STATE_WIDTH      = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slv_mem.sv
// Single-port register-file RAM: synchronous write, asynchronous read of one address.
module apb_slv_mem #(
    parameter int unsigned DATA_WIDTH = apb_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
    parameter int unsigned DEPTH      = apb_pkg::UPPER_ADDR_LIMIT
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    import apb_pkg::*;

    // Contents are deliberately never reset so they survive a bus reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_in_range;

    assign w_in_range = 32'(i_addr) < DEPTH;

    always_ff @(posedge i_clk) begin
        if (i_we && w_in_range) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = w_in_range ? r_mem[i_addr] : '0;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer in front of a DEPTH x DATA_WIDTH register file.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per access; otherwise zero-wait.
module apb_slave_regfile #(
    parameter int unsigned DATA_WIDTH  = apb_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = apb_pkg::ADDR_WIDTH,
    parameter int unsigned DEPTH       = apb_pkg::UPPER_ADDR_LIMIT,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);
    import apb_pkg::*;

    apb_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_write;
    logic                  r_err;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;

`ifdef APB_SLV_WAIT_EN
    logic [3:0]            r_cnt;
`else
    logic [3:0]            w_unused_wait;
    assign w_unused_wait = 4'(WAIT_CYCLES);
`endif

    logic                  w_setup;
    logic                  w_addr_err;
    logic                  w_in_idle;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic                  w_mem_we;
    logic                  w_resp_err;
    logic                  w_resp_rd;
    logic [DATA_WIDTH-1:0] w_resp_data;

    assign w_setup    = psel & ~penable;
    assign w_addr_err = 32'(paddr) >= DEPTH;
    assign w_in_idle  = (r_state == StIdle);

    // A zero-wait entry to RESP must read the live address, since the latch fills on that edge.
    assign w_mem_addr  = w_in_idle ? paddr : r_addr;
    assign w_resp_err  = w_in_idle ? w_addr_err : r_err;
    assign w_resp_rd   = w_in_idle ? ~pwrite : ~r_write;
    assign w_resp_data = (w_resp_rd && !w_resp_err) ? w_mem_rdata : '0;

    assign w_mem_we = (r_state == StResp) & psel & penable & r_write & ~r_err & ~preset;

    apb_slv_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk   (pclk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
`ifdef APB_SLV_WAIT_EN
            r_cnt     <= '0;
`endif
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_setup) begin
                        r_addr  <= paddr;
                        r_wdata <= pwdata;
                        r_write <= pwrite;
                        r_err   <= w_addr_err;
`ifdef APB_SLV_WAIT_EN
                        if (WAIT_CYCLES > 0) begin
                            r_state <= StWait;
                            r_cnt   <= 4'(WAIT_CYCLES);
                        end else begin
                            r_state   <= StResp;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_resp_err;
                            r_prdata  <= w_resp_data;
                        end
`else
                        r_state   <= StResp;
                        r_pready  <= 1'b1;
                        r_pslverr <= w_resp_err;
                        r_prdata  <= w_resp_data;
`endif
                    end
                end
`ifdef APB_SLV_WAIT_EN
                StWait: begin
                    if (!psel) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt <= 4'd1) begin
                            r_state   <= StResp;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_resp_err;
                            r_prdata  <= w_resp_data;
                        end
                    end
                end
`endif
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule
